smg_byte_fifo: RTL

//  Byte buffer between the UART receiver and the seven-segment display stage.

---
 rtl/smg_byte_fifo.sv | 117 +++++++++++
 1 files changed

// File: rtl/smg_byte_fifo.sv
// Circular byte FIFO between the UART receiver and the seven-segment display.
// Each rising edge of rdsig_nextdata pops one byte into the held output register.
module smg_byte_fifo #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AW        = 4,
  parameter logic [7:0]  IDLE_BYTE = 8'h00
) (
  input  logic          clk_50MHz,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          rdsig_nextdata,
  output logic [7:0]    data,
  output logic          data_valid,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow
);

  if ((DEPTH < 2) || (DEPTH != (1 << AW))) begin : g_param_check
    $error("smg_byte_fifo: DEPTH must be a power of two >= 2 and equal 2**AW");
  end

  localparam logic [AW:0] DepthCount = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic [7:0]    data_q, data_d;
  logic          data_valid_q, data_valid_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          req_q;

  logic          pop_req;
  logic          do_pop;
  logic          do_wr;

  // A held-high request produces exactly one pop; after reset req_q=0 so an
  // already-high level counts as an edge on the first cycle.
  assign pop_req = rdsig_nextdata & ~req_q;

  // When full, DEPTH >= 2 guarantees a pop is possible, so it frees the slot
  // this cycle's write lands in.
  assign do_pop  = pop_req & ~empty_q;
  assign do_wr   = wr_en & (~full_q | pop_req);

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    data_d       = data_q;
    data_valid_d = data_valid_q;
    count_d      = count_q + (AW+1)'(do_wr) - (AW+1)'(do_pop);
    empty_d      = (count_d == '0);
    full_d       = (count_d == DepthCount);
    overflow_d   = wr_en & full_q & ~pop_req;
    underflow_d  = pop_req & empty_q;

    if (do_wr) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d     = rd_ptr_q + AW'(1);
      data_d       = mem[rd_ptr_q];
      data_valid_d = 1'b1;
    end
  end

  // Storage has no reset; a full-FIFO write hits mem[rd_ptr_q] on the same edge
  // that reads it, and the read sees the old byte.
  always_ff @(posedge clk_50MHz) begin
    if (do_wr) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      empty_q      <= 1'b1;
      full_q       <= 1'b0;
      data_q       <= IDLE_BYTE;
      data_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      req_q        <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      empty_q      <= empty_d;
      full_q       <= full_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
      req_q        <= rdsig_nextdata;
    end
  end

  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign empty      = empty_q;
  assign full       = full_q;
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule
